// File: rtl/zx128_video_pkg.sv
// Shared timing constants, fetch phases and pixel/attribute types for the
// 128K video scanner.
package zx128_video_pkg;

   localparam int unsigned HC_W    = 9;
   localparam int unsigned VC_W    = 9;
   localparam int unsigned FLASH_W = 5;
   localparam int unsigned VA_W    = 13;

   localparam logic [HC_W-1:0] HC_DISP      = HC_W'(256);
   localparam logic [VC_W-1:0] VC_DISP      = VC_W'(192);
   localparam logic [HC_W-1:0] HC_WIN_START = HC_W'(8);
   localparam logic [HC_W-1:0] HC_WIN_END   = HC_W'(264);

   localparam logic [HC_W-1:0] HBLANK_START = HC_W'(320);
   localparam logic [HC_W-1:0] HBLANK_END   = HC_W'(416);
   localparam logic [HC_W-1:0] HSYNC_START  = HC_W'(344);
   localparam logic [HC_W-1:0] HSYNC_END    = HC_W'(376);
   localparam logic [VC_W-1:0] VBLANK_START = VC_W'(248);
   localparam logic [VC_W-1:0] VBLANK_END   = VC_W'(256);
   localparam logic [VC_W-1:0] VSYNC_START  = VC_W'(248);
   localparam logic [VC_W-1:0] VSYNC_END    = VC_W'(252);

   localparam logic [2:0] PH_BMP_FETCH  = 3'd1;
   localparam logic [2:0] PH_ATTR_FETCH = 3'd3;
   localparam logic [2:0] PH_BMP_LATCH  = 3'd2;
   localparam logic [2:0] PH_ATTR_LATCH = 3'd4;
   localparam logic [2:0] PH_LOAD       = 3'd7;
   localparam logic [2:0] ATTR_BASE     = 3'b110;

   typedef struct packed {
      logic g;
      logic r;
      logic b;
      logic i;
   } rgbi_t;

   typedef struct packed {
      logic       flash;
      logic       bright;
      logic [2:0] paper;
      logic [2:0] ink;
   } attr_t;

   // Colour codes are GRB, so they drop straight into rgbi_t.
   function automatic rgbi_t pixel_colour(input attr_t a, input logic ink_on);
      logic [2:0] grb;
      grb = ink_on ? a.ink : a.paper;
      return rgbi_t'({grb, a.bright});
   endfunction

endpackage

// File: rtl/zx128_video_counter.sv
// Horizontal/vertical beam counters and the 5-bit flash counter; the *_next_c
// outputs are the counter values after the coming ce.
module zx128_video_counter
   import zx128_video_pkg::*;
#(
   parameter int unsigned HTOTAL = 456,
   parameter int unsigned VTOTAL = 311
)(
   input  logic            clock,
   input  logic            reset,
   input  logic            ce,
   output logic [HC_W-1:0] hc,
   output logic [VC_W-1:0] vc,
   output logic            flash_on,
   output logic [HC_W-1:0] hc_next_c,
   output logic [VC_W-1:0] vc_next_c
);

   logic [FLASH_W-1:0] flash;
   logic               line_wrap;
   logic               frame_wrap;

   always_comb begin
      line_wrap  = (hc == HC_W'(HTOTAL - 1));
      frame_wrap = line_wrap && (vc == VC_W'(VTOTAL - 1));
      hc_next_c  = line_wrap ? '0 : hc + 1'b1;
      vc_next_c  = vc;
      if (frame_wrap) begin
         vc_next_c = '0;
      end else if (line_wrap) begin
         vc_next_c = vc + 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hc    <= '0;
         vc    <= '0;
         flash <= '0;
      end else if (ce) begin
         hc <= hc_next_c;
         vc <= vc_next_c;
         if (frame_wrap) begin
            flash <= flash + 1'b1;
         end
      end
   end

   assign flash_on = flash[FLASH_W-1];

endmodule

// File: rtl/zx128_video.sv
// 128K-timed video scanner: fetches bitmap/attribute bytes from video RAM,
// serialises pixels to RGBI, generates syncs/blanking/IRQ and CPU contention.
module zx128_video
   import zx128_video_pkg::*;
#(
   parameter int unsigned HTOTAL  = 456,
   parameter int unsigned VTOTAL  = 311,
   parameter int unsigned IRQLINE = 248,
   parameter int unsigned IRQLEN  = 64
)(
   input  logic            clock,
   input  logic            reset,
   input  logic            ce,
   input  logic [2:0]      border,
   input  logic            cn,
   output logic [VA_W-1:0] va,
   output logic            vce,
   input  logic [7:0]      vq,
   output logic            wait_c,
   output logic            irq,
   output logic            hsync,
   output logic            vsync,
   output logic            hblank,
   output logic            vblank,
   output logic            r,
   output logic            g,
   output logic            b,
   output logic            i
);

   logic [HC_W-1:0] hc;
   logic [HC_W-1:0] hc_nxt;
   logic [VC_W-1:0] vc;
   logic [VC_W-1:0] vc_nxt;
   logic            flash_on;

   logic [7:0] bitmap;
   logic [7:0] shift;
   logic [7:0] shift_nxt;
   attr_t      attr_latch;
   attr_t      attr;
   attr_t      attr_nxt;
   rgbi_t      rgbi;
   rgbi_t      rgbi_nxt;

   logic [2:0] phase;
   logic       in_disp;
   logic       in_win;
   logic       hblank_cond;
   logic       vblank_cond;
   logic       pix_on;

   zx128_video_counter #(
      .HTOTAL (HTOTAL),
      .VTOTAL (VTOTAL)
   ) u_counter (
      .clock     (clock),
      .reset     (reset),
      .ce        (ce),
      .hc        (hc),
      .vc        (vc),
      .flash_on  (flash_on),
      .hc_next_c (hc_nxt),
      .vc_next_c (vc_nxt)
   );

   // rgbi is registered, so colour is chosen for the pixel shown after this ce.
   always_comb begin
      phase       = hc[2:0];
      in_disp     = (vc < VC_DISP) && (hc < HC_DISP);
      in_win      = (vc_nxt < VC_DISP) && (hc_nxt >= HC_WIN_START) && (hc_nxt < HC_WIN_END);
      hblank_cond = (hc >= HBLANK_START) && (hc < HBLANK_END);
      vblank_cond = (vc >= VBLANK_START) && (vc < VBLANK_END);
      shift_nxt   = {shift[6:0], 1'b0};
      attr_nxt    = attr;
      if (in_disp && (phase == PH_LOAD)) begin
         shift_nxt = bitmap;
         attr_nxt  = attr_latch;
      end
      pix_on   = shift_nxt[7] ^ (attr_nxt.flash & flash_on);
      rgbi_nxt = rgbi_t'({border, 1'b0});
      if (hblank_cond || vblank_cond) begin
         rgbi_nxt = '0;
      end else if (in_win) begin
         rgbi_nxt = pixel_colour(attr_nxt, pix_on);
      end
   end

   // Address/enable are registered one phase early so they are valid during phases 1 and 3.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         va         <= '0;
         vce        <= 1'b0;
         bitmap     <= '0;
         attr_latch <= '0;
         shift      <= '0;
         attr       <= '0;
         rgbi       <= '0;
         hsync      <= 1'b0;
         vsync      <= 1'b0;
         hblank     <= 1'b0;
         vblank     <= 1'b0;
         irq        <= 1'b1;
      end else if (ce) begin
         vce <= 1'b0;
         if (in_disp && (phase == PH_BMP_FETCH - 3'd1)) begin
            vce <= 1'b1;
            va  <= {vc[7:6], vc[2:0], vc[5:3], hc[7:3]};
         end else if (in_disp && (phase == PH_ATTR_FETCH - 3'd1)) begin
            vce <= 1'b1;
            va  <= {ATTR_BASE, vc[7:3], hc[7:3]};
         end
         if (in_disp && (phase == PH_BMP_LATCH)) begin
            bitmap <= vq;
         end
         if (in_disp && (phase == PH_ATTR_LATCH)) begin
            attr_latch <= attr_t'(vq);
         end
         shift  <= shift_nxt;
         attr   <= attr_nxt;
         rgbi   <= rgbi_nxt;
         hblank <= hblank_cond;
         vblank <= vblank_cond;
         hsync  <= (hc >= HSYNC_START) && (hc < HSYNC_END);
         vsync  <= (vc >= VSYNC_START) && (vc < VSYNC_END);
         irq    <= ~((vc == VC_W'(IRQLINE)) && (hc < HC_W'(IRQLEN)));
      end
   end

   // Contention window gives 6,5,4,3,2,1,0,0 stall T-states per 8 T-states.
   assign wait_c = cn & in_disp & (hc[3:1] < 3'd6);

   assign g = rgbi.g;
   assign r = rgbi.r;
   assign b = rgbi.b;
   assign i = rgbi.i;

endmodule

// File: tb/tb_zx128_video.sv
// Bench for zx128_video: full-size instance plus a short-frame instance,
// random ce/cn/border against a screen-layout reference model, plus vectors.
module tb_zx128_video;

   localparam int HT    = 456;
   localparam int VT_M  = 311;
   localparam int IL_M  = 248;
   localparam int VT_S  = 4;
   localparam int IL_S  = 2;
   localparam int K_END = 30000;

   localparam int F_VA   = 0;
   localparam int F_VCE  = 1;
   localparam int F_GRBI = 2;
   localparam int F_IRQ  = 3;
   localparam int F_HS   = 4;
   localparam int F_HB   = 5;
   localparam int F_WT   = 6;

   typedef struct packed {
      logic [12:0] va;
      logic        vce;
      logic        wt;
      logic        irq;
      logic        hs;
      logic        vs;
      logic        hb;
      logic        vb;
      logic [3:0]  grbi;
   } out_t;

   typedef struct {
      int sm;
      int f;
      int v;
      int h;
      int fld;
      int expv;
   } vec_t;

   logic       clock = 1'b0;
   logic       reset;
   logic       ce;
   logic       cn;
   logic [2:0] border;

   logic [12:0] va_m, va_s;
   logic        vce_m, vce_s, wt_m, wt_s, irq_m, irq_s;
   logic        hs_m, hs_s, vs_m, vs_s, hb_m, hb_s, vb_m, vb_s;
   logic        r_m, r_s, g_m, g_s, b_m, b_s, i_m, i_s;
   logic [7:0]  vq_m, vq_s;

   logic [7:0] mem [0:8191];
   out_t       cap_m [0:K_END];
   out_t       cap_s [0:K_END];
   vec_t       vecs [$];

   int         k;
   logic [2:0] bord_ref;
   int         checks = 0;
   int         errors = 0;

   always #5 clock = ~clock;

   zx128_video u_main (
      .clock (clock), .reset (reset), .ce (ce), .border (border), .cn (cn),
      .va (va_m), .vce (vce_m), .vq (vq_m), .wait_c (wt_m), .irq (irq_m),
      .hsync (hs_m), .vsync (vs_m), .hblank (hb_m), .vblank (vb_m),
      .r (r_m), .g (g_m), .b (b_m), .i (i_m)
   );

   zx128_video #(.VTOTAL (VT_S), .IRQLINE (IL_S)) u_small (
      .clock (clock), .reset (reset), .ce (ce), .border (border), .cn (cn),
      .va (va_s), .vce (vce_s), .vq (vq_s), .wait_c (wt_s), .irq (irq_s),
      .hsync (hs_s), .vsync (vs_s), .hblank (hb_s), .vblank (vb_s),
      .r (r_s), .g (g_s), .b (b_s), .i (i_s)
   );

   // Synchronous video RAM read port: data appears on the ce after vce.
   always @(posedge clock) begin
      if (ce && vce_m) vq_m <= mem[va_m];
      if (ce && vce_s) vq_s <= mem[va_s];
   end

   function automatic int bmp_addr(input int x, input int y);
      return (y / 64) * 2048 + (y % 8) * 256 + ((y / 8) % 8) * 32 + x / 8;
   endfunction

   function automatic int attr_addr(input int x, input int y);
      return 6144 + (y / 8) * 32 + x / 8;
   endfunction

   // Expected outputs after k pixel clocks since reset release.
   function automatic out_t model(input int kk, input int vt, input int il,
                                  input logic [2:0] bord, input logic cnv);
      out_t o;
      int h, v, hp, vp, fp, x;
      logic [7:0] bm, at;
      logic bitv;
      o = '0;
      o.irq = 1'b1;
      h = kk % HT;
      v = (kk / HT) % vt;
      o.wt = cnv && (v < 192) && (h < 256) && ((h % 16) < 12);
      if (kk == 0) return o;
      hp = (kk - 1) % HT;
      vp = ((kk - 1) / HT) % vt;
      fp = ((kk - 1) / (HT * vt)) % 32;
      o.vce = (v < 192) && (h < 256) && ((h % 8 == 1) || (h % 8 == 3));
      if (o.vce) o.va = 13'((h % 8 == 1) ? bmp_addr(h, v) : attr_addr(h, v));
      o.hb  = (hp >= 320) && (hp < 416);
      o.hs  = (hp >= 344) && (hp < 376);
      o.vb  = (vp >= 248) && (vp < 256);
      o.vs  = (vp >= 248) && (vp < 252);
      o.irq = !((vp == il) && (hp < 64));
      if (o.hb || o.vb) begin
         o.grbi = 4'd0;
      end else if ((v < 192) && (h >= 8) && (h < 264)) begin
         x    = h - 8;
         bm   = mem[bmp_addr(x, v)];
         at   = mem[attr_addr(x, v)];
         bitv = bm[3'(7 - x % 8)] ^ (at[7] & (fp >= 16));
         o.grbi = bitv ? {at[2:0], at[6]} : {at[5:3], at[6]};
      end else begin
         o.grbi = {bord, 1'b0};
      end
      return o;
   endfunction

   function automatic int field(input out_t o, input int fld);
      case (fld)
         F_VA:    return int'(o.va);
         F_VCE:   return int'(o.vce);
         F_GRBI:  return int'(o.grbi);
         F_IRQ:   return int'(o.irq);
         F_HS:    return int'(o.hs);
         F_HB:    return int'(o.hb);
         default: return int'(o.wt);
      endcase
   endfunction

   task automatic cmp_out(input string tag, input int kk, input out_t act, input out_t exp);
      out_t m;
      m = '1;
      if (!(exp.vce || kk == 0)) m.va = '0;
      checks++;
      if ((act & m) !== (exp & m)) begin
         errors++;
         $display("FAIL %s k=%0d got=%h want=%h", tag, kk, act & m, exp & m);
      end
   endtask

   task automatic add_vec(input int sm, input int f, input int v, input int h,
                          input int fld, input int expv);
      vec_t e;
      e.sm = sm; e.f = f; e.v = v; e.h = h; e.fld = fld; e.expv = expv;
      vecs.push_back(e);
   endtask

   task automatic sample_and_check();
      out_t am, as;
      am = out_t'({va_m, vce_m, wt_m, irq_m, hs_m, vs_m, hb_m, vb_m, g_m, r_m, b_m, i_m});
      as = out_t'({va_s, vce_s, wt_s, irq_s, hs_s, vs_s, hb_s, vb_s, g_s, r_s, b_s, i_s});
      cmp_out("main", k, am, model(k, VT_M, IL_M, bord_ref, cn));
      cmp_out("small", k, as, model(k, VT_S, IL_S, bord_ref, cn));
      cap_m[k] = am;
      cap_s[k] = as;
   endtask

   // Random ce gaps, random cn (forced high on main line 10), rare border changes.
   task automatic run_stream(input int k_end);
      int   kn;
      logic cen;
      while (k < k_end) begin
         cen = ($urandom_range(0, 3) != 0);
         kn  = k + (cen ? 1 : 0);
         cn  = (kn / HT == 10) ? 1'b1 : 1'($urandom_range(0, 1));
         if ($urandom_range(0, 99) == 0) border = 3'($urandom_range(0, 7));
         ce = cen;
         if (cen) bord_ref = border;
         @(negedge clock);
         k = kn;
         sample_and_check();
      end
   endtask

   initial begin
      for (int n = 0; n < 8192; n++) mem[n] = 8'($urandom);
      mem[0]        = 8'h80;
      mem[1]        = 8'h80;
      mem[13'h1800] = 8'h47;
      mem[13'h1801] = 8'h87;

      // {dut, frame, line, column, field, expected}
      add_vec(0, 0, 0, 1, F_VCE, 1);
      add_vec(0, 0, 0, 1, F_VA, 'h0000);
      add_vec(0, 0, 0, 2, F_VCE, 0);
      add_vec(0, 0, 0, 3, F_VCE, 1);
      add_vec(0, 0, 0, 3, F_VA, 'h1800);
      add_vec(0, 0, 65, 17, F_VCE, 1);
      add_vec(0, 0, 65, 17, F_VA, 'h0902);
      add_vec(0, 0, 65, 19, F_VA, 'h1902);
      add_vec(0, 0, 0, 8, F_GRBI, 'b1111);
      add_vec(0, 0, 0, 9, F_GRBI, 'b0001);
      add_vec(0, 0, 0, 15, F_GRBI, 'b0001);
      add_vec(0, 0, 0, 320, F_HB, 0);
      add_vec(0, 0, 0, 321, F_HB, 1);
      add_vec(0, 0, 0, 416, F_HB, 1);
      add_vec(0, 0, 0, 417, F_HB, 0);
      add_vec(0, 0, 0, 344, F_HS, 0);
      add_vec(0, 0, 0, 345, F_HS, 1);
      add_vec(0, 0, 0, 376, F_HS, 1);
      add_vec(0, 0, 0, 377, F_HS, 0);
      add_vec(0, 0, 10, 0, F_WT, 1);
      add_vec(0, 0, 10, 11, F_WT, 1);
      add_vec(0, 0, 10, 12, F_WT, 0);
      add_vec(0, 0, 10, 15, F_WT, 0);
      add_vec(0, 0, 10, 16, F_WT, 1);
      add_vec(0, 0, 10, 251, F_WT, 1);
      add_vec(0, 0, 10, 255, F_WT, 0);
      add_vec(0, 0, 10, 256, F_WT, 0);
      add_vec(1, 1, 2, 0, F_IRQ, 1);
      add_vec(1, 1, 2, 1, F_IRQ, 0);
      add_vec(1, 1, 2, 64, F_IRQ, 0);
      add_vec(1, 1, 2, 65, F_IRQ, 1);
      add_vec(1, 15, 0, 16, F_GRBI, 'b1110);
      add_vec(1, 15, 0, 17, F_GRBI, 'b0000);
      add_vec(1, 16, 0, 16, F_GRBI, 'b0000);
      add_vec(1, 16, 0, 17, F_GRBI, 'b1110);

      reset  = 1'b1;
      ce     = 1'b0;
      cn     = 1'b0;
      border = 3'd2;
      repeat (3) @(negedge clock);
      k = 0;
      bord_ref = border;
      sample_and_check();
      reset = 1'b0;

      run_stream(K_END);

      foreach (vecs[n]) begin
         int   vt, kk, act;
         out_t o;
         vt  = (vecs[n].sm != 0) ? VT_S : VT_M;
         kk  = vecs[n].f * HT * vt + vecs[n].v * HT + vecs[n].h;
         o   = (vecs[n].sm != 0) ? cap_s[kk] : cap_m[kk];
         act = field(o, vecs[n].fld);
         checks++;
         if (act != vecs[n].expv) begin
            errors++;
            $display("FAIL vec%0d dut=%0d f=%0d v=%0d h=%0d fld=%0d got=%0h want=%0h",
                     n, vecs[n].sm, vecs[n].f, vecs[n].v, vecs[n].h, vecs[n].fld,
                     act, vecs[n].expv);
         end
      end

      // Mid-line reset (main beam sits inside hsync): outputs clear at once,
      // then the scan restarts from the top-left corner.
      cn = 1'b0;
      ce = 1'b0;
      #2 reset = 1'b1;
      #1;
      k = 0;
      sample_and_check();
      @(negedge clock);
      reset = 1'b0;
      run_stream(600);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
